// File: rtl/bsg_arb_rr_one_hot_hold_pkg.sv
// Shared helpers for the round-robin one-hot arbiter slice.
package bsg_arb_rr_one_hot_hold_pkg;

  // Tag width for a requester count; a single requester still needs one bit.
  function automatic int unsigned tag_width_f(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bsg_encode_one_hot.sv
// One-hot (or zero) to binary index conversion.
module bsg_encode_one_hot #(
  parameter int unsigned width_p     = 32,
  parameter int unsigned tag_width_p = 5
) (
  input  logic [width_p-1:0]     i,
  output logic [tag_width_p-1:0] addr_o
);

  always_comb begin
    addr_o = '0;
    for (int k = 0; k < width_p; k++) begin
      if (i[k]) addr_o = addr_o | tag_width_p'(k);
    end
  end

endmodule

// File: rtl/bsg_priority_encode_one_hot_out.sv
// Fixed-priority one-hot picker: lowest set bit when lo_to_hi_p=1, highest otherwise.
module bsg_priority_encode_one_hot_out #(
  parameter int unsigned width_p    = 32,
  parameter int unsigned lo_to_hi_p = 0
) (
  input  logic [width_p-1:0] i,
  output logic [width_p-1:0] o
);

  if (lo_to_hi_p != 0) begin : g_lo
    assign o = i & (~i + width_p'(1));
  end else begin : g_hi
    logic [width_p-1:0] rev_i;
    logic [width_p-1:0] rev_o;
    // Reverse, isolate the lowest bit, reverse back to get the highest bit.
    for (genvar k = 0; k < width_p; k++) begin : g_rev
      assign rev_i[k] = i[width_p-1-k];
      assign o[k]     = rev_o[width_p-1-k];
    end
    assign rev_o = rev_i & (~rev_i + width_p'(1));
  end

endmodule

// File: rtl/bsg_arb_rr_one_hot_hold.sv
// Round-robin arbiter with one-hot grant, binary tag and optional grant hold.
// Grant is combinational from reqs_i and state; state advances on handshake.
module bsg_arb_rr_one_hot_hold
  import bsg_arb_rr_one_hot_hold_pkg::*;
#(
  parameter int unsigned width_p         = 32,
  parameter int unsigned lo_to_hi_p      = 0,
  parameter int unsigned hold_on_valid_p = 1,
  localparam int unsigned tag_width_lp   = tag_width_f(width_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [width_p-1:0]      reqs_i,
  input  logic                    yumi_i,
  output logic [width_p-1:0]      grants_o,
  output logic [tag_width_lp-1:0] tag_o,
  output logic                    v_o
);

  localparam logic [tag_width_lp-1:0] last_reset_lp =
    (lo_to_hi_p != 0) ? tag_width_lp'(width_p - 1) : '0;

  logic [tag_width_lp-1:0] last_r;
  logic [tag_width_lp-1:0] held_tag_r;
  logic                    held_v_r;

  logic [width_p-1:0] mask;
  logic [width_p-1:0] held_oh;
  logic [width_p-1:0] masked_reqs;
  logic [width_p-1:0] masked_grant;
  logic [width_p-1:0] unmasked_grant;
  logic [width_p-1:0] search_grant;
  logic [width_p-1:0] grant_raw;
  logic [tag_width_lp-1:0] tag_raw;
  logic               held_hit;

  // Thermometer mask: indices strictly past last_r in the search direction.
  for (genvar k = 0; k < width_p; k++) begin : g_mask
    if (lo_to_hi_p != 0) begin : g_up
      assign mask[k] = (tag_width_lp'(k) > last_r);
    end else begin : g_dn
      assign mask[k] = (tag_width_lp'(k) < last_r);
    end
    assign held_oh[k] = (held_tag_r == tag_width_lp'(k));
  end

  assign masked_reqs = reqs_i & mask;

  bsg_priority_encode_one_hot_out #(
    .width_p    (width_p),
    .lo_to_hi_p (lo_to_hi_p)
  ) u_pe_masked (
    .i (masked_reqs),
    .o (masked_grant)
  );

  bsg_priority_encode_one_hot_out #(
    .width_p    (width_p),
    .lo_to_hi_p (lo_to_hi_p)
  ) u_pe_unmasked (
    .i (reqs_i),
    .o (unmasked_grant)
  );

  assign search_grant = (|masked_reqs) ? masked_grant : unmasked_grant;

  // A hold only wins while the held requester is still asking.
  assign held_hit  = (hold_on_valid_p != 0) && held_v_r && (|(held_oh & reqs_i));
  assign grant_raw = held_hit ? held_oh : search_grant;

  bsg_encode_one_hot #(
    .width_p     (width_p),
    .tag_width_p (tag_width_lp)
  ) u_enc (
    .i      (grant_raw),
    .addr_o (tag_raw)
  );

  assign grants_o = reset_n_i ? grant_raw : '0;
  assign tag_o    = reset_n_i ? tag_raw   : '0;
  assign v_o      = reset_n_i & (|reqs_i);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      last_r     <= last_reset_lp;
      held_v_r   <= 1'b0;
      held_tag_r <= '0;
    end else if (v_o) begin
      if (yumi_i) begin
        last_r   <= tag_o;
        held_v_r <= 1'b0;
      end else begin
        held_v_r   <= (hold_on_valid_p != 0);
        held_tag_r <= tag_o;
      end
    end else begin
      held_v_r <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert ($onehot0(grants_o)) else $error("grants_o not one-hot0");
      assert ((grants_o & ~reqs_i) == '0) else $error("grant without request");
      assert (!(yumi_i && !v_o)) else $error("yumi_i without v_o");
      if (held_hit) begin
        assert (grants_o == held_oh) else $error("held grant moved");
      end
    end
  end
`endif

endmodule

// File: tb/tb_bsg_arb_rr_one_hot_hold.sv
// Checks four arbiter configurations against a search-order reference model.
module tb_bsg_arb_rr_one_hot_hold;

  localparam int W [4] = '{4, 4, 1, 64};
  localparam int D [4] = '{0, 1, 0, 1};

  logic clk;
  logic rst_n;
  logic [3:0][63:0] req;
  logic [3:0]       yumi;
  logic [3:0]       v;
  logic [3:0]  g0, g1;
  logic [0:0]  g2;
  logic [63:0] g3;
  logic [1:0]  t0, t1;
  logic [0:0]  t2;
  logic [5:0]  t3;
  logic [3:0][63:0] obs_g;
  logic [3:0][63:0] obs_t;

  int n_chk;
  int n_bad;
  int m_last [4];
  int m_hv [4];
  int m_ht [4];
  int exp_p [4];

  bsg_arb_rr_one_hot_hold #(.width_p(4), .lo_to_hi_p(0), .hold_on_valid_p(1)) u_w4_dn (
    .clk_i(clk), .reset_n_i(rst_n), .reqs_i(req[0][3:0]), .yumi_i(yumi[0]),
    .grants_o(g0), .tag_o(t0), .v_o(v[0]));
  bsg_arb_rr_one_hot_hold #(.width_p(4), .lo_to_hi_p(1), .hold_on_valid_p(1)) u_w4_up (
    .clk_i(clk), .reset_n_i(rst_n), .reqs_i(req[1][3:0]), .yumi_i(yumi[1]),
    .grants_o(g1), .tag_o(t1), .v_o(v[1]));
  bsg_arb_rr_one_hot_hold #(.width_p(1), .lo_to_hi_p(0), .hold_on_valid_p(1)) u_w1 (
    .clk_i(clk), .reset_n_i(rst_n), .reqs_i(req[2][0:0]), .yumi_i(yumi[2]),
    .grants_o(g2), .tag_o(t2), .v_o(v[2]));
  bsg_arb_rr_one_hot_hold #(.width_p(64), .lo_to_hi_p(1), .hold_on_valid_p(1)) u_w64 (
    .clk_i(clk), .reset_n_i(rst_n), .reqs_i(req[3]), .yumi_i(yumi[3]),
    .grants_o(g3), .tag_o(t3), .v_o(v[3]));

  assign obs_g[0] = 64'(g0);
  assign obs_g[1] = 64'(g1);
  assign obs_g[2] = 64'(g2);
  assign obs_g[3] = g3;
  assign obs_t[0] = 64'(t0);
  assign obs_t[1] = 64'(t1);
  assign obs_t[2] = 64'(t2);
  assign obs_t[3] = 64'(t3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference: honour a live hold, else walk indices from last in search order.
  function automatic int pick(input logic [63:0] r, input int w, input int dir,
                              input int last, input int hv, input int ht);
    int idx;
    if (hv != 0 && r[ht]) return ht;
    for (int k = 1; k <= w; k++) begin
      idx = (dir != 0) ? (last + k) % w : (last - k + w) % w;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check_all();
    logic [63:0] r;
    int p;
    for (int i = 0; i < 4; i++) begin
      r = req[i] & wmask(W[i]);
      p = rst_n ? pick(r, W[i], D[i], m_last[i], m_hv[i], m_ht[i]) : -1;
      exp_p[i] = p;
      chk($sformatf("grant%0d", i), obs_g[i], (p < 0) ? 64'd0 : (64'd1 << p));
      chk($sformatf("tag%0d", i), obs_t[i], (p < 0) ? 64'd0 : 64'(p));
      chk($sformatf("v%0d", i), 64'(v[i]), 64'(rst_n && (r != 0)));
    end
  endtask

  task automatic settle();
    @(negedge clk);
    check_all();
  endtask

  task automatic advance();
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        m_last[i] = (D[i] != 0) ? W[i] - 1 : 0;
        m_hv[i]   = 0;
      end else if (exp_p[i] >= 0) begin
        if (yumi[i]) begin
          m_last[i] = exp_p[i];
          m_hv[i]   = 0;
        end else begin
          m_hv[i] = 1;
          m_ht[i] = exp_p[i];
        end
      end else begin
        m_hv[i] = 0;
      end
    end
    #1;
  endtask

  task automatic rand_in(input int i);
    logic [63:0] r;
    case ($urandom % 5)
      0:       r = '1;
      1:       r = {$urandom, $urandom};
      2:       r = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      3:       r = '0;
      default: r = 64'd1 << ($urandom % 64);
    endcase
    req[i]  = r & wmask(W[i]);
    yumi[i] = rst_n && (req[i] != 0) && ($urandom % 3 != 0);
  endtask

  task automatic set_in(input int i, input logic [63:0] r, input logic y);
    req[i]  = r;
    yumi[i] = y;
  endtask

  initial begin
    int t, cnt, served;
    n_chk = 0;
    n_bad = 0;
    for (int i = 0; i < 4; i++) begin
      m_last[i] = (D[i] != 0) ? W[i] - 1 : 0;
      m_hv[i]   = 0;
      m_ht[i]   = 0;
      exp_p[i]  = -1;
    end
    rst_n = 1'b0;
    yumi  = '0;
    for (int i = 0; i < 4; i++) req[i] = wmask(W[i]);
    #1;
    repeat (2) begin
      settle();
      chk("rst_g0", 64'(g0), 64'd0);
      chk("rst_v3", 64'(v[3]), 64'd0);
      advance();
    end

    // Full rotation, alternate pair, and width-1 pass-through.
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_in(0, 64'hF, 1'b1);
      set_in(1, 64'hA, 1'b1);
      set_in(2, 64'(k % 2), 1'(k % 2));
      rand_in(3);
      settle();
      chk("rr_grant", 64'(g0), 64'(4'b1000 >> (k % 4)));
      chk("rr_tag", 64'(t0), 64'(3 - (k % 4)));
      chk("up_grant", 64'(g1), (k % 2 != 0) ? 64'h8 : 64'h2);
      chk("w1_grant", 64'(g2), 64'(k % 2));
      chk("w1_tag", 64'(t2), 64'd0);
      advance();
    end

    // Hold sequence on the 4-wide descending instance.
    set_in(0, 64'h1, 1'b1); settle(); chk("pre_hold", 64'(g0), 64'h1); advance();
    repeat (3) begin
      set_in(0, 64'h4, 1'b0); settle(); chk("hold_solo", 64'(g0), 64'h4); advance();
    end
    set_in(0, 64'hC, 1'b0); settle();
    chk("hold_keep", 64'(g0), 64'h4); chk("hold_tag", 64'(t0), 64'd2); advance();
    set_in(0, 64'hC, 1'b1); settle(); chk("hold_yumi", 64'(g0), 64'h4); advance();
    set_in(0, 64'hC, 1'b0); settle(); chk("post_yumi", 64'(g0), 64'h8); advance();
    set_in(0, 64'h4, 1'b0); settle(); chk("hold_on2", 64'(g0), 64'h4); advance();
    set_in(0, 64'h1, 1'b0); settle();
    chk("drop_g", 64'(g0), 64'h1); chk("drop_t", 64'(t0), 64'd0); chk("drop_v", 64'(v[0]), 64'd1);
    advance();

    // Reset while a hold is active.
    for (int i = 0; i < 4; i++) set_in(i, wmask(W[i]), 1'b0);
    settle(); advance();
    rst_n = 1'b0;
    repeat (2) begin
      settle();
      chk("rst_hold_g", 64'(g0), 64'd0); chk("rst_hold_t", 64'(t0), 64'd0);
      advance();
    end
    rst_n = 1'b1;
    settle();
    chk("post_rst_dn", 64'(g0), 64'h8); chk("post_rst_up", 64'(g1), 64'h1);
    chk("post_rst_64", g3, 64'h1);
    advance();

    // Random traffic on all instances.
    repeat (1500) begin
      for (int i = 0; i < 4; i++) rand_in(i);
      settle();
      advance();
    end

    // Fairness: a continuously requesting port on the 64-wide instance.
    for (int n = 0; n < 5; n++) begin
      case (n)
        0: t = 0;
        1: t = 17;
        2: t = 40;
        3: t = 63;
        default: t = int'($urandom % 64);
      endcase
      cnt = 0;
      served = 0;
      for (int c = 0; c < 2000 && served == 0; c++) begin
        for (int i = 0; i < 3; i++) rand_in(i);
        req[3]  = {$urandom, $urandom} | (64'd1 << t);
        yumi[3] = ($urandom % 4 != 0);
        settle();
        if (yumi[3] && g3[t]) served = 1;
        else if (yumi[3]) cnt++;
        advance();
      end
      chk($sformatf("fair_served%0d", t), 64'(served), 64'd1);
      chk($sformatf("fair_bound%0d", t), 64'(cnt <= 63), 64'd1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
